// File: rtl/alu_writeback_if.sv
// ALU output bus as seen by the writeback stage.
//   in_valid          : the ALU output this cycle belongs to a real instruction
//   in_rd             : destination register index
//   result            : ALU result
//   nzcv              : ALU flags, [3]=N [2]=Z [1]=C [0]=V
//   result_writeback  : commit result to in_rd
//   nzcv_writeback    : commit nzcv to the CPSR flags
// The ALU drives the bus through the master modport. The writeback stage
// consumes it through the slave modport.
interface alu_writeback_if #(
   parameter int DW = 32
);
   logic          in_valid;
   logic [3:0]    in_rd;
   logic [DW-1:0] result;
   logic [3:0]    nzcv;
   logic          result_writeback;
   logic          nzcv_writeback;

   modport master (
      output in_valid, in_rd, result, nzcv, result_writeback, nzcv_writeback
   );

   modport slave (
      input  in_valid, in_rd, result, nzcv, result_writeback, nzcv_writeback
   );
endinterface

// File: rtl/alu_writeback.sv
// Writeback stage behind the data-processing ALU.
// It captures each ALU result into a pending stage (P). On the following edge
// it commits that result into a 16 x DW register file and the CPSR NZCV flags.
// Operand and flag reads forward from P, so a result is readable one cycle
// after it is presented.
// Ports:
//   clk, reset      : rising-edge clock, asynchronous active-low reset
//   alu             : ALU output bus (slave side)
//   ra_addr/rb_addr : operand read addresses
//   ra_data/rb_data : forwarded operand data (combinational)
//   flags           : forwarded architectural NZCV
//   carry_in        : flags[1], for ADC/SBC/RSC
//   pc_load         : one-cycle pulse after an R15 commit
//   pc_value        : last committed R15, word aligned
//   retire_count    : committed instruction count, wraps
module alu_writeback #(
   parameter int NREGS = 16,
   parameter int DW    = 32
) (
   input  logic              clk,
   input  logic              reset,
   alu_writeback_if.slave    alu,
   input  logic [3:0]        ra_addr,
   input  logic [3:0]        rb_addr,
   output logic [DW-1:0]     ra_data,
   output logic [DW-1:0]     rb_data,
   output logic [3:0]        flags,
   output logic              carry_in,
   output logic              pc_load,
   output logic [DW-1:0]     pc_value,
   output logic [31:0]       retire_count
);

   // Pending stage
   logic          p_valid_reg;
   logic [3:0]    p_rd_reg;
   logic [DW-1:0] p_result_reg;
   logic [3:0]    p_nzcv_reg;
   logic          p_we_r_reg;
   logic          p_we_f_reg;

   // Architectural state
   logic [DW-1:0] regs_reg [NREGS];
   logic [3:0]    cpsr_nzcv_reg;
   logic          pc_load_reg;
   logic [DW-1:0] pc_value_reg;
   logic [31:0]   retire_count_reg;

   logic          commit_r;
   logic          commit_f;
   logic          commit_pc;
   logic [NREGS-1:0] reg_wr_sel;

   assign commit_r  = p_valid_reg && p_we_r_reg;
   assign commit_f  = p_valid_reg && p_we_f_reg;
   assign commit_pc = commit_r && (p_rd_reg == 4'd15);

   // One-hot write select per architectural register
   generate
      for (genvar gi = 0; gi < NREGS; gi++) begin : g_wr_sel
         assign reg_wr_sel[gi] = commit_r && (p_rd_reg == 4'(gi));
      end
   endgenerate

   // P loads on every edge. An in-flight instruction is dropped by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         p_valid_reg  <= 1'b0;
         p_rd_reg     <= '0;
         p_result_reg <= '0;
         p_nzcv_reg   <= '0;
         p_we_r_reg   <= 1'b0;
         p_we_f_reg   <= 1'b0;
      end else begin
         p_valid_reg  <= alu.in_valid;
         p_rd_reg     <= alu.in_rd;
         p_result_reg <= alu.result;
         p_nzcv_reg   <= alu.nzcv;
         p_we_r_reg   <= alu.result_writeback;
         p_we_f_reg   <= alu.nzcv_writeback;
      end
   end

   // Register file. It must clear on reset, so it is built from flops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (reg_wr_sel[i]) begin
               regs_reg[i] <= p_result_reg;
            end
         end
      end
   end

   // Flags, PC load pulse, and retire counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cpsr_nzcv_reg    <= '0;
         pc_load_reg      <= 1'b0;
         pc_value_reg     <= '0;
         retire_count_reg <= '0;
      end else begin
         pc_load_reg <= commit_pc;
         if (commit_f) begin
            cpsr_nzcv_reg <= p_nzcv_reg;
         end
         if (commit_pc) begin
            pc_value_reg <= {p_result_reg[DW-1:2], 2'b00};
         end
         if (p_valid_reg) begin
            retire_count_reg <= retire_count_reg + 32'd1;
         end
      end
   end

   // Reads forward the pending result. This hides the one-cycle commit delay.
   assign ra_data = (commit_r && (p_rd_reg == ra_addr)) ? p_result_reg : regs_reg[ra_addr];
   assign rb_data = (commit_r && (p_rd_reg == rb_addr)) ? p_result_reg : regs_reg[rb_addr];
   assign flags   = commit_f ? p_nzcv_reg : cpsr_nzcv_reg;

   assign carry_in     = flags[1];
   assign pc_load      = pc_load_reg;
   assign pc_value     = pc_value_reg;
   assign retire_count = retire_count_reg;

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback.
// The reference model holds the architectural view a reader sees. A presented
// instruction becomes visible to reads after its capture edge. Counter and PC
// effects lag by one edge, when the instruction commits.
module tb_alu_writeback;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  ra_addr = '0;
   logic [3:0]  rb_addr = '0;
   logic [31:0] ra_data, rb_data, pc_value, retire_count;
   logic [3:0]  flags;
   logic        carry_in, pc_load;

   alu_writeback_if #(.DW(32)) bus ();

   alu_writeback #(.NREGS(16), .DW(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .alu          (bus),
      .ra_addr      (ra_addr),
      .rb_addr      (rb_addr),
      .ra_data      (ra_data),
      .rb_data      (rb_data),
      .flags        (flags),
      .carry_in     (carry_in),
      .pc_load      (pc_load),
      .pc_value     (pc_value),
      .retire_count (retire_count)
   );

   always #5 clk = ~clk;

   int tests  = 0;
   int failed = 0;

   // Reference model
   logic [31:0] m_regs [16];
   logic [3:0]  m_flags;
   logic [31:0] m_count;
   logic [31:0] m_pc;
   logic        m_pcload;
   logic        pend_v, pend_wr;
   logic [3:0]  pend_rd;
   logic [31:0] pend_res;

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_flags  = '0;
      m_count  = '0;
      m_pc     = '0;
      m_pcload = 1'b0;
      pend_v   = 1'b0;
      pend_wr  = 1'b0;
      pend_rd  = '0;
      pend_res = '0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".ra"},       ra_data,             m_regs[ra_addr]);
      check({tag, ".rb"},       rb_data,             m_regs[rb_addr]);
      check({tag, ".flags"},    {28'd0, flags},      {28'd0, m_flags});
      check({tag, ".carry"},    {31'd0, carry_in},   {31'd0, m_flags[1]});
      check({tag, ".pc_load"},  {31'd0, pc_load},    {31'd0, m_pcload});
      check({tag, ".pc_value"}, pc_value,            m_pc);
      check({tag, ".retire"},   retire_count,        m_count);
   endtask

   // Present one ALU output, clock it in, update the model, then check.
   task automatic step(input logic v, input logic [3:0] rd, input logic [31:0] res,
                       input logic [3:0] nz, input logic wr, input logic wf,
                       input logic [3:0] ra, input logic [3:0] rb, input string tag);
      bus.in_valid         = v;
      bus.in_rd            = rd;
      bus.result           = res;
      bus.nzcv             = nz;
      bus.result_writeback = wr;
      bus.nzcv_writeback   = wf;
      ra_addr              = ra;
      rb_addr              = rb;
      @(posedge clk);
      // The instruction that was pending commits at this edge.
      m_pcload = 1'b0;
      if (pend_v) begin
         m_count = m_count + 32'd1;
         if (pend_wr && pend_rd == 4'd15) begin
            m_pcload = 1'b1;
            m_pc     = pend_res & ~32'd3;
         end
      end
      // The new instruction becomes visible through forwarding.
      if (v && wr) m_regs[rd] = res;
      if (v && wf) m_flags = nz;
      pend_v   = v;
      pend_wr  = wr;
      pend_rd  = rd;
      pend_res = res;
      #1;
      check_all(tag);
   endtask

   task automatic idle(input logic [3:0] ra, input string tag);
      step(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 1'b0, ra, 4'd0, tag);
   endtask

   initial begin
      model_reset();
      bus.in_valid         = 1'b0;
      bus.in_rd            = '0;
      bus.result           = '0;
      bus.nzcv             = '0;
      bus.result_writeback = 1'b0;
      bus.nzcv_writeback   = 1'b0;

      // Reset held while the bus toggles. Nothing may be captured.
      for (int i = 0; i < 4; i++) begin
         bus.in_valid         = i[0];
         bus.in_rd            = 4'(i + 3);
         bus.result           = 32'hA5A5_0000 + 32'(i);
         bus.nzcv             = 4'hF;
         bus.result_writeback = 1'b1;
         bus.nzcv_writeback   = 1'b1;
         @(posedge clk);
      end
      #1;
      bus.in_valid = 1'b0;
      reset = 1'b1;
      for (int r = 0; r < 16; r++) begin
         ra_addr = 4'(r);
         rb_addr = 4'(15 - r);
         #1;
         check("reset", ra_data, 32'd0);
         check("reset", rb_data, 32'd0);
      end
      check_all("reset");

      // ADD: forwarded from P, then read from the register file
      step(1'b1, 4'd3, 32'd30, 4'd0, 1'b1, 1'b0, 4'd3, 4'd0, "add_fwd");
      check("add_fwd_lit", ra_data, 32'd30);
      idle(4'd3, "add_commit");
      check("add_commit_cnt", retire_count, 32'd1);

      // CMP: only the flags change
      step(1'b1, 4'd5, 32'd2, 4'b0010, 1'b0, 1'b1, 4'd5, 4'd3, "cmp");
      check("cmp_carry_lit", {31'd0, carry_in}, 32'd1);
      idle(4'd5, "cmp_commit");
      check("cmp_r5_lit", ra_data, 32'd0);

      // Back-to-back writes to the same rd
      step(1'b1, 4'd7, 32'h11, 4'd0, 1'b1, 1'b0, 4'd7, 4'd7, "b2b_1");
      check("b2b_1_lit", ra_data, 32'h11);
      step(1'b1, 4'd7, 32'h22, 4'd0, 1'b1, 1'b0, 4'd7, 4'd7, "b2b_2");
      check("b2b_2_lit", ra_data, 32'h22);
      idle(4'd7, "b2b_3");
      check("b2b_3_lit", ra_data, 32'h22);

      // PC write, then R14 write must not pulse pc_load
      step(1'b1, 4'd15, 32'h0000_1003, 4'd0, 1'b1, 1'b0, 4'd15, 4'd0, "pc_w");
      step(1'b1, 4'd14, 32'h0000_2003, 4'd0, 1'b1, 1'b0, 4'd14, 4'd15, "pc_r14");
      check("pc_pulse_lit", {31'd0, pc_load}, 32'd1);
      check("pc_value_lit", pc_value, 32'h0000_1000);
      idle(4'd14, "pc_after");
      check("pc_low_lit", {31'd0, pc_load}, 32'd0);

      // Discarded result still retires
      step(1'b1, 4'd9, 32'hFFFF, 4'hF, 1'b0, 1'b0, 4'd9, 4'd0, "nop_wr");
      idle(4'd9, "nop_commit");

      // Reset before R2's commit edge
      step(1'b1, 4'd2, 32'hDEAD, 4'd0, 1'b1, 1'b0, 4'd2, 4'd0, "mid_rst_pre");
      reset = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      check("mid_rst_async_r2", ra_data, 32'd0);
      check("mid_rst_async_cnt", retire_count, 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      idle(4'd2, "mid_rst_post");
      check("mid_rst_r2_lit", ra_data, 32'd0);

      // Retire counter wrap
      force dut.retire_count_reg = 32'hFFFF_FFFF;
      #1;
      release dut.retire_count_reg;
      m_count = 32'hFFFF_FFFF;
      step(1'b1, 4'd1, 32'h1, 4'd0, 1'b1, 1'b0, 4'd1, 4'd0, "wrap_issue");
      idle(4'd1, "wrap_commit");
      check("wrap_lit", retire_count, 32'd0);

      // Randomized traffic, biased toward R15 and register reuse
      for (int n = 0; n < 300; n++) begin
         logic [3:0] rd;
         rd = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
         step($urandom_range(0, 3) != 0, rd, $urandom, 4'($urandom),
              1'($urandom), 1'($urandom),
              ($urandom_range(0, 1) == 0) ? rd : 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Writeback stage behind the data-processing ALU: captures each ALU result and its `result_writeback`/`nzcv_writeback` qualifiers, commits them to the 16 x 32-bit register file and the CPSR NZCV flags, and serves operand reads and carry-in back to the ALU issue logic with forwarding. It is the consumer end of the ALU output interface (`result`, `nzcv`, `result_writeback`, `nzcv_writeback`). It also raises a PC-load pulse when R15 is written.

## Interface
- `NREGS`, 16: number of architectural registers; fixed at 16, with R15 being the PC.
- `DW`, 32: data width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  ALU output this cycle is a real instruction.
- `in_rd`  in  4  destination register index.
- `result`  in  DW  ALU result.
- `nzcv`  in  4  ALU flags: [3]=N, [2]=Z, [1]=C, [0]=V.
- `result_writeback`  in  1  write `result` to `in_rd`.
- `nzcv_writeback`  in  1  write `nzcv` to CPSR flags.
- `ra_addr`, `rb_addr`  in  4 each  operand read addresses.
- `ra_data`, `rb_data`  out  DW each  operand read data, combinational and forwarded.
- `flags`  out  4  current architectural NZCV, forwarded.
- `carry_in`  out  1  equal to `flags[1]`; used by the ALU for ADC, SBC and RSC.
- `pc_load`  out  1  one-cycle pulse: R15 was committed.
- `pc_value`  out  DW  committed R15 value with bits [1:0] forced to 0. Holds its value between loads.
- `retire_count`  out  32  number of committed instructions; wraps.

## Operation
- The block has two stages: P (pending register) and C (commit into the register file and flag register).
- **P stage.** At every clock edge, P loads `p_valid=in_valid`, together with `in_rd`, `result`, `nzcv`, `result_writeback` and `nzcv_writeback`. When `in_valid=0`, P holds `p_valid=0`.
- **Commit, when `p_valid=1`:**
  - If `p_we_r`, then `regs[p_rd] <= p_result`.
  - If `p_we_f`, then `cpsr_nzcv <= p_nzcv`.
  - `retire_count` increments, wrapping from 0xFFFFFFFF to 0.
  - If `p_we_r` and `p_rd==15`, `pc_load` asserts in the following cycle and `pc_value <= p_result & ~3`.
- **Register read with forwarding.** `ra_data = (p_valid && p_we_r && p_rd==ra_addr) ? p_result : regs[ra_addr]`. `rb_data` is formed the same way.
- **Flag read with forwarding.** `flags = (p_valid && p_we_f) ? p_nzcv : cpsr_nzcv`.
- **No write requested.** An instruction with `in_valid=1` but both write enables 0 (e.g. a discarded result) still retires and increments the counter, but changes no state.
- **Compare/test instructions.** TST, TEQ, CMP and CMN arrive with `result_writeback=0` and `nzcv_writeback=1`. Only the flags update.
- **Back-to-back writes to the same rd.** The younger write sits in P and wins on forwarding. The older write has already committed. No write is lost.
- **Simultaneous read and commit of the same register.** Forwarding returns the P value, so the read never returns stale data.
- **Writes to R0..R14** never assert `pc_load`.
- **Reset (asynchronous, active-low).**
  - All registers and `cpsr_nzcv` clear to 0.
  - `p_valid=0`.
  - `pc_load=0`, `pc_value=0`, `retire_count=0`.
  - An instruction pending in P when reset asserts is discarded and never commits.
  - Outputs take their reset values immediately, independent of `clk`.
- There is no backpressure. The block accepts one instruction every cycle.

## Timing
- An instruction presented at edge N is in P after edge N. It is architecturally visible in `regs`/`cpsr` after edge N+1.
- Forwarded data is visible on `ra_data`, `rb_data` and `flags` in the cycle after edge N, i.e. effective read latency is 1.
- `pc_load` is high for exactly the cycle after the commit edge (N+1 to N+2), then returns low unless another R15 write commits.
- `retire_count` increments at the commit edge (N+1).
- `carry_in` follows `flags[1]` combinationally.
- Reset deassertion: the first instruction is accepted at the first `clk` rising edge after `reset` goes high.

## Test plan
- **Reset.** Hold `reset=0` with `in_valid=1` toggling, then release.
  - Required: all `ra_data`/`rb_data` reads return 0; `flags=0000`, `pc_load=0`, `retire_count=0`.
- **ADD forward then commit.** Present `in_rd=3`, `result=30`, `result_writeback=1`, `nzcv_writeback=0`, with `ra_addr=3`.
  - Next cycle: `ra_data=30` (from P).
  - The cycle after: `ra_data=30` (from the register file); `retire_count=1`.
- **CMP flags only.** Present `nzcv=0010`, `result_writeback=0`, `nzcv_writeback=1`, `in_rd=5`, `result=2`.
  - Required: `flags=0010` and `carry_in=1` one cycle later; R5 is unchanged at 0.
- **Back-to-back same rd.** Write R7=0x11, then R7=0x22 on consecutive cycles; read R7 each cycle.
  - Required: reads return 0x11, then 0x22, then 0x22.
- **PC write.** Present `in_rd=15`, `result=0x0000_1003`, `result_writeback=1`.
  - Required: `pc_load` is a one-cycle pulse at N+1 with `pc_value=0x0000_1000`.
  - A following write to R14 must leave `pc_load` low.
- **Reset mid-operation.** Present R2=0xDEAD, then assert `reset` before the commit edge.
  - Required: after release, R2 reads 0 and `retire_count=0`.
- **Wrap.** Preload `retire_count=0xFFFFFFFF` via a force, then retire one instruction.
  - Required: `retire_count=0`.
